// File: rtl/sevenseg_pkg.sv
// Shared glyph constants, slot-latch payload and helpers for the 7-segment scan driver.
package sevenseg_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Per-slot snapshot taken at slot start
    typedef struct packed {
        logic [3:0] nib;
        logic       dp_req;
        logic       blank;
        logic       sup;
    } slot_t;

    localparam slot_t SLOT_DARK = '{nib: 4'h0, dp_req: 1'b0, blank: 1'b1, sup: 1'b0};

    // Ceiling log2, never below 1 so index buses stay at least one bit wide
    function automatic int unsigned clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r < 1) ? 1 : int'(r);
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Display-side bundle: digit data/controls from the datapath and the pin-level scan outputs.
interface sevenseg_scan_driver_if #(
    parameter int unsigned N_DIGITS = 4
);
    import sevenseg_pkg::*;

    localparam int unsigned IDX_W = clog2(N_DIGITS);

    logic [4*N_DIGITS-1:0] din;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic                  lzs;
    logic [3:0]            bright;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   en;
    logic                  slot_tick;
    logic [IDX_W-1:0]      digit_idx;

    modport master (
        output din, dp_in, blank_in, lzs, bright,
        input  seg, dp, en, slot_tick, digit_idx
    );

    modport slave (
        input  din, dp_in, blank_in, lzs, bright,
        output seg, dp, en, slot_tick, digit_idx
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment glyph {g,f,e,d,c,b,a}.
module seg7_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg_c = SEG_0;
            4'h1: o_seg_c = SEG_1;
            4'h2: o_seg_c = SEG_2;
            4'h3: o_seg_c = SEG_3;
            4'h4: o_seg_c = SEG_4;
            4'h5: o_seg_c = SEG_5;
            4'h6: o_seg_c = SEG_6;
            4'h7: o_seg_c = SEG_7;
            4'h8: o_seg_c = SEG_8;
            4'h9: o_seg_c = SEG_9;
            4'hA: o_seg_c = SEG_A;
            4'hB: o_seg_c = SEG_B;
            4'hC: o_seg_c = SEG_C;
            4'hD: o_seg_c = SEG_D;
            4'hE: o_seg_c = SEG_E;
            4'hF: o_seg_c = SEG_F;
            default: o_seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: prescaled slot scan, LZS, per-digit dp/blank,
// 16-level PWM brightness and an anti-ghost dark cycle at each slot start.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned REFRESH_DIV    = 8192,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
    input logic                   clk,
    input logic                   clr,
    sevenseg_scan_driver_if.slave bus
);

    localparam int unsigned DIV_W = clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = clog2(N_DIGITS);

    logic [DIV_W-1:0]    r_pc;
    logic [IDX_W-1:0]    r_idx;
    slot_t               r_slot;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [N_DIGITS-1:0] r_en;
    logic                r_slot_tick;
    logic [IDX_W-1:0]    r_digit_idx;

    logic                w_slot_start;
    logic                w_pc_last;
    logic [DIV_W-1:0]    w_pc_nxt;
    logic [N_DIGITS-1:0] w_zero_above;
    slot_t               w_live;
    slot_t               w_cur;
    logic [6:0]          w_glyph;
    logic                w_dark;
    logic                w_lit;
    logic [N_DIGITS-1:0] w_en_hot;

    assign w_slot_start = (r_pc == '0);
    assign w_pc_last    = (r_pc == DIV_W'(REFRESH_DIV - 1));
    assign w_pc_nxt     = r_pc + DIV_W'(1);

    // w_zero_above[i]: nibbles N_DIGITS-1 down to i are all zero
    always_comb begin
        w_zero_above = '0;
        w_zero_above[N_DIGITS-1] = (bus.din[4*(N_DIGITS-1) +: 4] == 4'h0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            w_zero_above[i] = w_zero_above[i+1] & (bus.din[4*i +: 4] == 4'h0);
        end
    end

    // Live view of the digit selected by the scan index
    always_comb begin
        w_live = SLOT_DARK;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_live.nib    = bus.din[4*i +: 4];
                w_live.dp_req = bus.dp_in[i];
                w_live.blank  = bus.blank_in[i];
                w_live.sup    = bus.lzs & (i != 0) & w_zero_above[i];
            end
        end
    end

    // At slot start the outputs are computed straight from the live sample, so they
    // show the new digit one cycle later without an extra pipeline stage.
    assign w_cur = w_slot_start ? w_live : r_slot;

    seg7_hex_decode u_decode (
        .i_nib   (w_cur.nib),
        .o_seg_c (w_glyph)
    );

    assign w_dark = w_cur.blank | w_cur.sup;

    // en for the next cycle: never at pc==0, otherwise gated by PWM phase
    assign w_lit    = ~w_dark & (w_pc_nxt != '0) & (w_pc_nxt[DIV_W-1 -: 4] <= bus.bright);
    assign w_en_hot = w_lit ? (N_DIGITS'(1) << r_idx) : '0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pc        <= '0;
            r_idx       <= '0;
            r_slot      <= SLOT_DARK;
            r_seg       <= seg_pol(SEG_BLANK, SEG_ACTIVE_LOW);
            r_dp        <= SEG_ACTIVE_LOW;
            r_en        <= {N_DIGITS{EN_ACTIVE_LOW}};
            r_slot_tick <= 1'b0;
            r_digit_idx <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_pc_last) begin
                r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end
            if (w_slot_start) begin
                r_slot      <= w_live;
                r_digit_idx <= r_idx;
            end
            r_slot_tick <= w_slot_start;
            r_seg       <= seg_pol(w_dark ? SEG_BLANK : w_glyph, SEG_ACTIVE_LOW);
            r_dp        <= (w_cur.dp_req & ~w_cur.blank) ^ SEG_ACTIVE_LOW;
            r_en        <= w_en_hot ^ {N_DIGITS{EN_ACTIVE_LOW}};
        end
    end

    assign bus.seg       = r_seg;
    assign bus.dp        = r_dp;
    assign bus.en        = r_en;
    assign bus.slot_tick = r_slot_tick;
    assign bus.digit_idx = r_digit_idx;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with N_DIGITS=4, REFRESH_DIV=16, active-low pins.
module tb_sevenseg_scan_driver;

    localparam int unsigned ND  = 4;
    localparam int unsigned DIV = 16;
    localparam int NV = 30;

    typedef struct {
        logic [15:0] din;
        logic [3:0]  dp_in;
        logic [3:0]  blank_in;
        logic        lzs;
        logic [3:0]  bright;
        int          digit;
        logic [6:0]  seg;
        logic        dp;
        logic        lit;
    } vec_t;

    logic clk;
    logic clr;
    logic clk_on;
    int   cyc;
    int   n_checks;
    int   n_fail;
    vec_t vecs [NV];

    sevenseg_scan_driver_if #(.N_DIGITS(ND)) bus ();

    sevenseg_scan_driver #(
        .N_DIGITS       (ND),
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .EN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always begin
        #5;
        if (clk_on) clk = ~clk;
    end

    // Reference position in the scan: posedges since reset release
    always @(posedge clk or posedge clr) begin
        if (clr) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int cur_pc();
        return cyc % DIV;
    endfunction

    function automatic int cur_slot();
        return (cyc / DIV) % ND;
    endfunction

    function automatic vec_t mk(input logic [15:0] din, input logic [3:0] dpi, input logic [3:0] bli,
                                input logic lzs, input logic [3:0] br, input int digit,
                                input logic [6:0] seg, input logic dp, input logic lit);
        vec_t v;
        v.din = din; v.dp_in = dpi; v.blank_in = bli; v.lzs = lzs; v.bright = br;
        v.digit = digit; v.seg = seg; v.dp = dp; v.lit = lit;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.din      = v.din;
        bus.dp_in    = v.dp_in;
        bus.blank_in = v.blank_in;
        bus.lzs      = v.lzs;
        bus.bright   = v.bright;
    endtask

    task automatic goto_pos(input int s, input int p);
        for (int k = 0; k < 200; k++) begin
            if (cur_slot() == s && cur_pc() == p) return;
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL goto slot %0d pc %0d: position not reached", s, p);
    endtask

    logic [3:0] exp_en;
    logic       seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        clk_on   = 1'b0;
        clr      = 1'b1;

        //          din      dp     blank  lzs  br    dig seg    dp    lit
        vecs[0]  = mk(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 0, 7'h19, 1'b1, 1'b1);
        vecs[1]  = mk(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 1, 7'h30, 1'b1, 1'b1);
        vecs[2]  = mk(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 2, 7'h24, 1'b1, 1'b1);
        vecs[3]  = mk(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 3, 7'h79, 1'b1, 1'b1);
        vecs[4]  = mk(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 0, 7'h19, 1'b1, 1'b1);
        vecs[5]  = mk(16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 1, 7'h12, 1'b1, 1'b1);
        vecs[6]  = mk(16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 2, 7'h7F, 1'b1, 1'b0);
        vecs[7]  = mk(16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 3, 7'h7F, 1'b1, 1'b0);
        vecs[8]  = mk(16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 0, 7'h40, 1'b1, 1'b1);
        vecs[9]  = mk(16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, 1, 7'h7F, 1'b1, 1'b0);
        vecs[10] = mk(16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, 2, 7'h7F, 1'b1, 1'b0);
        vecs[11] = mk(16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, 3, 7'h7F, 1'b1, 1'b0);
        vecs[12] = mk(16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, 0, 7'h40, 1'b1, 1'b1);
        vecs[13] = mk(16'h1234, 4'h0, 4'h0, 1'b0, 4'h3, 1, 7'h30, 1'b1, 1'b1);
        vecs[14] = mk(16'h1234, 4'h0, 4'h0, 1'b0, 4'h0, 2, 7'h24, 1'b1, 1'b1);
        vecs[15] = mk(16'hABCD, 4'h8, 4'h0, 1'b0, 4'hF, 3, 7'h08, 1'b0, 1'b1);
        vecs[16] = mk(16'hABCD, 4'h8, 4'h0, 1'b0, 4'hF, 0, 7'h21, 1'b1, 1'b1);
        vecs[17] = mk(16'hABCD, 4'h8, 4'h0, 1'b0, 4'hF, 1, 7'h46, 1'b1, 1'b1);
        vecs[18] = mk(16'hABCD, 4'h4, 4'h4, 1'b0, 4'hF, 2, 7'h7F, 1'b1, 1'b0);
        vecs[19] = mk(16'h000E, 4'h8, 4'h0, 1'b1, 4'hF, 3, 7'h7F, 1'b0, 1'b0);
        vecs[20] = mk(16'h000E, 4'h0, 4'h0, 1'b1, 4'hF, 0, 7'h06, 1'b1, 1'b1);
        vecs[21] = mk(16'h00F0, 4'h2, 4'h2, 1'b1, 4'hF, 1, 7'h7F, 1'b1, 1'b0);
        vecs[22] = mk(16'h0B00, 4'h0, 4'h0, 1'b1, 4'hF, 2, 7'h03, 1'b1, 1'b1);
        vecs[23] = mk(16'h0B00, 4'h0, 4'h0, 1'b1, 4'hF, 3, 7'h7F, 1'b1, 1'b0);
        vecs[24] = mk(16'h9876, 4'h0, 4'h0, 1'b0, 4'hF, 0, 7'h02, 1'b1, 1'b1);
        vecs[25] = mk(16'h9876, 4'h0, 4'h0, 1'b0, 4'hF, 1, 7'h78, 1'b1, 1'b1);
        vecs[26] = mk(16'h9876, 4'h0, 4'h0, 1'b0, 4'h8, 2, 7'h00, 1'b1, 1'b1);
        vecs[27] = mk(16'h9876, 4'h0, 4'h0, 1'b0, 4'hF, 3, 7'h10, 1'b1, 1'b1);
        vecs[28] = mk(16'h000F, 4'h0, 4'h0, 1'b0, 4'hF, 0, 7'h0E, 1'b1, 1'b1);
        vecs[29] = mk(16'h000F, 4'h0, 4'h0, 1'b0, 4'hF, 1, 7'h40, 1'b1, 1'b1);

        // Reset applied with no clock running
        apply(vecs[0]);
        #1;
        chk("rst_seg",  32'(bus.seg), 32'h7F);
        chk("rst_dp",   32'(bus.dp), 32'h1);
        chk("rst_en",   32'(bus.en), 32'hF);
        chk("rst_idx",  32'(bus.digit_idx), 32'h0);
        chk("rst_tick", 32'(bus.slot_tick), 32'h0);
        #1;
        clr    = 1'b0;
        clk_on = 1'b1;

        // One slot per vector; vector v>0 is applied in the pc==0 cycle of its slot
        for (int v = 0; v < NV; v++) begin
            if (v > 0) begin
                apply(vecs[v]);
                chk("pc0_en",   32'(bus.en), 32'hF);
                chk("pc0_tick", 32'(bus.slot_tick), 32'h0);
            end
            for (int p = 1; p < DIV; p++) begin
                @(negedge clk);
                exp_en = (vecs[v].lit && p <= int'(vecs[v].bright)) ? ~(4'b0001 << vecs[v].digit) : 4'hF;
                chk("seg",  32'(bus.seg), 32'(vecs[v].seg));
                chk("dp",   32'(bus.dp), 32'(vecs[v].dp));
                chk("en",   32'(bus.en), 32'(exp_en));
                chk("tick", 32'(bus.slot_tick), (p == 1) ? 32'h1 : 32'h0);
                chk("idx",  32'(bus.digit_idx), 32'(vecs[v].digit));
            end
            @(negedge clk);
        end

        // din changed mid-slot: glyph holds until the digit's next slot start
        goto_pos(1, 0);
        apply(vecs[1]);
        for (int p = 1; p < DIV; p++) begin
            @(negedge clk);
            if (p == 5) bus.din = 16'h5678;
            chk("hold_seg", 32'(bus.seg), 32'h30);
        end
        goto_pos(1, 1);
        chk("revisit_seg", 32'(bus.seg), 32'h78);
        chk("revisit_idx", 32'(bus.digit_idx), 32'h1);

        // Asynchronous clear mid-slot, then restart from digit 0
        goto_pos(2, 7);
        clr = 1'b1;
        #1;
        chk("clr_seg",  32'(bus.seg), 32'h7F);
        chk("clr_dp",   32'(bus.dp), 32'h1);
        chk("clr_en",   32'(bus.en), 32'hF);
        chk("clr_idx",  32'(bus.digit_idx), 32'h0);
        chk("clr_tick", 32'(bus.slot_tick), 32'h0);
        #1;
        clr  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3 && !seen; k++) begin
            @(negedge clk);
            seen = bus.slot_tick;
        end
        chk("tick_after_clr", 32'(seen), 32'h1);
        chk("idx_after_clr",  32'(bus.digit_idx), 32'h0);
        chk("seg_after_clr",  32'(bus.seg), 32'h00);
        chk("en_after_clr",   32'(bus.en), 32'hE);
        @(negedge clk);
        chk("tick_one_cycle", 32'(bus.slot_tick), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
